// File: rtl/crumb_bank.sv
// crumb_bank: prescaled synchronous divide chain producing LANES derived clocks,
// per-lane reset/enable release after an INIT hold, and a whitened random-bit shifter.
module crumb_bank #(
    parameter int LANES      = 4,
    parameter int DIV_W      = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [LANES-1:0] lane_en,
    input  logic             rbit,
    input  logic             rbit2,
    output logic [LANES-1:0] clk_o,
    output logic [LANES-1:0] rst_no,
    output logic [LANES-1:0] en_o,
    output logic [LANES-1:0] rbit_o,
    output logic             busy
);

    // state | meaning
    // IDLE  | out of reset, all outputs low, waiting for en
    // INIT  | downstream resets held low for RST_CYCLES enabled cycles
    // RUN   | prescaler and divide chain running, lanes released per lane_en
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int INIT_W = $clog2(RST_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RST_CYCLES - 1);

    logic [1:0]        state;
    logic [DIV_W-1:0]  pcnt;
    logic [INIT_W-1:0] icnt;
    logic [LANES-1:0]  phase;
    logic [LANES-1:0]  phase_nxt;
    logic [LANES-1:0]  toggle;
    logic              carry;
    logic              tick;

    // >= rather than == so a div shrunk below the running count still ticks
    assign tick = (state == ST_RUN) && (pcnt >= div);
    assign busy = (state == ST_INIT);

    // A lane toggles when every lower lane is about to fall 1->0: a ripple carry.
    always_comb begin
        toggle = '0;
        carry  = tick;
        for (int i = 0; i < LANES; i++) begin
            toggle[i] = carry;
            carry     = carry & phase[i];
        end
        phase_nxt = phase ^ toggle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pcnt   <= '0;
            icnt   <= '0;
            phase  <= '0;
            clk_o  <= '0;
            rst_no <= '0;
            en_o   <= '0;
            rbit_o <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    state  <= ST_INIT;
                    icnt   <= '0;
                    clk_o  <= '0;
                    rst_no <= '0;
                    en_o   <= '0;
                end
                ST_INIT: begin
                    clk_o  <= '0;
                    rst_no <= '0;
                    en_o   <= '0;
                    if (icnt == INIT_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        icnt <= icnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    pcnt   <= tick ? '0 : pcnt + 1'b1;
                    phase  <= phase_nxt;
                    clk_o  <= phase_nxt & lane_en;
                    rst_no <= lane_en;
                    en_o   <= lane_en;
                    if (tick) begin
                        rbit_o <= {rbit_o[LANES-2:0], rbit ^ rbit2};
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/crumb_bank.md
Name: crumb_bank

Overview:
Parametrised, multi-lane successor to the single crumb cell. It takes one system clock and produces LANES derived clocks in a synchronous ripple-divide chain: lane 0 runs from a programmable prescaler, and each later lane runs at half the rate of the lane before it. It also produces per-lane released resets, per-lane enables, and a shifted whitened random-bit bus. The block sits between the top-level control inputs and the array of downstream cookie cells, replacing hand-chained crumb instances.

Parameters:
LANES, 4, number of output lanes (≥2)
DIV_W, 8, width of the prescaler divide input and counter
RST_CYCLES, 4, cycles that the downstream reset is held asserted in INIT (≥1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  global enable; low freezes all state
div  input  DIV_W  prescaler terminal count; lane-0 half-period = div+1 cycles
lane_en  input  LANES  per-lane output mask
rbit  input  1  random bit source 1
rbit2  input  1  random bit source 2
clk_o  output  LANES  derived clock per lane (registered)
rst_no  output  LANES  active-low reset per lane (registered)
en_o  output  LANES  enable per lane (registered)
rbit_o  output  LANES  random bit shift register (registered)
busy  output  1  high while in INIT

Behaviour:
- Async reset (rst=1): state=IDLE; prescaler counter=0, init counter=0; clk_o, rst_no, en_o, rbit_o, busy all 0.
- FSM states are IDLE, INIT and RUN. All transitions and counter updates happen only when en=1; when en=0 every register holds its value (freeze).
- IDLE: outputs stay 0. On en=1, go to INIT and clear the init counter.
- INIT: busy=1; rst_no=0, clk_o=0, en_o=0. The init counter increments each enabled cycle. When it reaches RST_CYCLES-1, go to RUN on the next edge. INIT therefore lasts exactly RST_CYCLES enabled cycles.
- RUN: busy=0; rst_no registers to lane_en and en_o registers to lane_en, one cycle after sampling.
- Prescaler (RUN only): the counter increments each cycle. tick=1 when counter ≥ div, and the counter returns to 0 on the same edge. With div=0, tick fires every cycle.
- Lane clocks: on tick, lane 0 toggles its internal phase. Lane i (i≥1) toggles in the same cycle in which lane i-1 goes from 1 to 0. This is a synchronous ripple with no combinational clocks.
- Lane masking: clk_o[i] = phase[i] AND lane_en[i], registered. The phases keep running while a lane is masked, so unmasking resumes in phase. A masked lane drives clk_o=0, rst_no=0 and en_o=0 from the next cycle.
- Random path: on each tick, rbit_o <= {rbit_o[LANES-2:0], rbit ^ rbit2}. rbit_o holds between ticks and during IDLE/INIT.
- Changing div mid-run: the ≥ compare means a new div below the current count produces a tick on the next cycle, then the new period applies. No lockup is allowed.
- en=0 in RUN: all outputs and counters hold, with no resync. en=1 resumes on the next cycle without re-entering INIT.
- Async reset mid-run: all outputs go to 0 immediately, regardless of clk. After rst falls, INIT must be re-run.
- Widths: the prescaler counter is DIV_W bits wide, the init counter is clog2(RST_CYCLES+1) bits wide, and the phase register is LANES bits wide.

Test Plan:
- Reset/INIT: rst pulse, then en=1, RST_CYCLES=4 -> busy=1 for exactly 4 cycles, rst_no=0 throughout, then rst_no=lane_en=4'b1111 one cycle after RUN entry.
- Divide chain: div=0, lane_en=4'hF -> clk_o[0] toggles every cycle, clk_o[1] every 2, clk_o[2] every 4, clk_o[3] every 8; div=2 -> clk_o[0] half-period of 3 cycles.
- Freeze: en dropped for 5 cycles mid-RUN -> clk_o, rbit_o and counters unchanged; after en returns, toggling resumes with the same phase and busy stays 0.
- Masking: lane_en=4'b0101 -> clk_o[1], clk_o[3], rst_no[1], rst_no[3], en_o[1] and en_o[3] are 0 next cycle; restoring 4'hF makes clk_o[1] equal the running phase[1].
- Random shift: div=0, rbit=1, rbit2=0 for 2 ticks then rbit=rbit2=1 -> rbit_o sequence 0001, 0011, 0110.
- Div shrink / async reset: count at 7 and div changed 9->3 -> tick next cycle then every 4 cycles; asserting rst mid-RUN -> all outputs 0 before the next clk edge, and state returns to IDLE.
